// File: rtl/loop_feedback_responder_if.sv
// Handshake bundle between the loop controller (master) and the
// ok_feedback responder (slave), plus the responder's debug state.
interface loop_feedback_responder_if;
   logic       enable;
   logic       sense;
   logic       ok_feedback;
   logic       ok_pulse;
   logic       fail;
   logic [2:0] state;

   modport master (
      output enable,
      output sense,
      input  ok_feedback,
      input  ok_pulse,
      input  fail,
      input  state
   );

   modport slave (
      input  enable,
      input  sense,
      output ok_feedback,
      output ok_pulse,
      output fail,
      output state
   );
endinterface

// File: rtl/loop_feedback_responder.sv
// Responder side of the loop enable/ok_feedback handshake: settle, qualify the
// in-regulation comparator for a stable window, report OK or a sticky timeout FAIL.
module loop_feedback_responder #(
   parameter int SETTLE_CYCLES  = 16,
   parameter int STABLE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input logic                      clk,
   input logic                      rst,
   loop_feedback_responder_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      QUALIFY = 3'd2,
      OK      = 3'd3,
      FAIL    = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic             enable_meta, enable_s;
   logic             sense_meta, sense_s;
   state_e           state_q, state_nxt;
   logic [CNT_W-1:0] cnt, stab, tcnt;
   logic             ok_feedback_q, ok_pulse_q, fail_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // NOTE: non-blocking assignments make each flop take its pre-edge input;
   // blocking ones here would collapse the two synchronizer stages into one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable_meta <= 1'b0;
         enable_s    <= 1'b0;
         sense_meta  <= 1'b0;
         sense_s     <= 1'b0;
      end else begin
         enable_meta <= bus.enable;
         enable_s    <= enable_meta;
         sense_meta  <= bus.sense;
         sense_s     <= sense_meta;
      end
   end

   // NOTE: state_nxt is defaulted before any branch so no path can infer a latch.
   always_comb begin
      state_nxt = state_q;
      if (!enable_s) begin
         state_nxt = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_nxt = SETTLE;
            SETTLE:  if (cnt == SETTLE_LAST) state_nxt = QUALIFY;
            QUALIFY: begin
               if (sense_s && (stab == STABLE_LAST)) state_nxt = OK;
               else if (tcnt == TIMEOUT_LAST)       state_nxt = FAIL;
            end
            OK:      if (!sense_s) state_nxt = QUALIFY;
            FAIL:    state_nxt = FAIL;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt           <= '0;
         stab          <= '0;
         tcnt          <= '0;
         ok_feedback_q <= 1'b0;
         ok_pulse_q    <= 1'b0;
         fail_q        <= 1'b0;
      end else begin
         state_q       <= state_nxt;
         ok_feedback_q <= (state_nxt == OK);
         ok_pulse_q    <= (state_nxt == OK) && (state_q != OK);
         fail_q        <= (state_nxt == FAIL);
         if (state_nxt != state_q) begin
            cnt  <= '0;
            stab <= '0;
            // The timeout budget spans SETTLE and QUALIFY as one window.
            tcnt <= (state_q == SETTLE && state_nxt == QUALIFY) ? sat_inc(tcnt) : '0;
         end else begin
            case (state_q)
               SETTLE: begin
                  cnt  <= sat_inc(cnt);
                  tcnt <= sat_inc(tcnt);
               end
               QUALIFY: begin
                  tcnt <= sat_inc(tcnt);
                  stab <= sense_s ? sat_inc(stab) : '0;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.ok_feedback = ok_feedback_q;
   assign bus.ok_pulse    = ok_pulse_q;
   assign bus.fail        = fail_q;
   assign bus.state       = state_q;

endmodule

// File: doc/loop_feedback_responder.md
Name: loop_feedback_responder

Overview:
- Responder end of the loop enable/ok_feedback handshake. The loop controller drives `enable`; this block drives `ok_feedback` back to it.
- Sits beside the regulated loop. On `enable` it waits a settle time, then requires the loop's in-regulation comparator (`sense`) to hold high for a qualify window before asserting `ok_feedback`.
- Flags `fail` if qualification does not complete within a timeout. Drops `ok_feedback` if regulation is lost.

Parameters:
- SETTLE_CYCLES, 16, cycles spent in SETTLE before `sense` is examined (≥1).
- STABLE_CYCLES, 8, consecutive cycles with `sense_s` high required to qualify (≥1).
- TIMEOUT_CYCLES, 1024, maximum cycles in SETTLE+QUALIFY before FAIL (> SETTLE_CYCLES+STABLE_CYCLES).
- CNT_W, 11, counter width; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  single block clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  loop enable from the controller; asynchronous level.
- sense  input  1  comparator in-regulation flag; asynchronous level.
- ok_feedback  output  1  level; high while state==OK.
- ok_pulse  output  1  one-cycle pulse on each entry to OK.
- fail  output  1  high while state==FAIL.
- state  output  3  debug: IDLE=0, SETTLE=1, QUALIFY=2, OK=3, FAIL=4.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (`rst`). During reset: synchronizer flops=0, state=IDLE, all counters=0, ok_feedback=0, ok_pulse=0, fail=0.
- Synchronizers: `enable` and `sense` each pass through a 2-flop synchronizer, giving `enable_s` and `sense_s`. The FSM uses only the synchronized versions.
- Outputs are registered decodes of the next state, so each output changes in the same cycle as `state`.
- Counters:
  - `cnt` is the settle counter.
  - `stab` is the stable counter.
  - `tcnt` is the timeout counter.
  - All counters are CNT_W bits and saturating. All clear on every state entry except where noted below.
- Global priority, highest first: `enable_s`=0 forces IDLE from any state, then OK qualification, then timeout.
- IDLE:
  - If `enable_s`=1, go to SETTLE next cycle.
  - Clear cnt, stab and tcnt.
- SETTLE:
  - cnt and tcnt increment each cycle.
  - When cnt==SETTLE_CYCLES-1, go to QUALIFY. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- QUALIFY:
  - tcnt keeps counting; it is not cleared on entry from SETTLE.
  - If `sense_s`=1, stab increments. If `sense_s`=0, stab clears to 0.
  - If `sense_s`=1 and stab==STABLE_CYCLES-1, go to OK.
  - Otherwise, if tcnt==TIMEOUT_CYCLES-1, go to FAIL.
  - If qualification and timeout occur in the same cycle, OK wins.
- OK:
  - ok_feedback=1.
  - If `sense_s`=0, go to QUALIFY with stab and tcnt cleared. ok_feedback drops in that same cycle, and the full timeout budget restarts.
- FAIL:
  - Sticky while `enable_s`=1.
  - Leave only via `enable_s`=0, which goes to IDLE. A retry requires `enable` to toggle low then high.
- ok_pulse is high for exactly one cycle on every transition into OK, including re-entry after loss of regulation.
- Latency from `enable` going high (stable before edge 1, `sense` already high and stable):
  - SETTLE after edge 3.
  - QUALIFY after edge 3+SETTLE_CYCLES.
  - OK / ok_feedback=1 after edge 3+SETTLE_CYCLES+STABLE_CYCLES; with defaults, edge 27.
- `enable` dropping mid-operation: state returns to IDLE 3 edges after the fall, with ok_feedback/fail=0 in the same cycle. Counters clear.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). Operation restarts from IDLE after release.

Test Plan:
- Nominal, defaults: rst released; `sense`=1 held; `enable` 0→1 before edge 1 -> state 1 at edge 3, state 2 at edge 19, ok_feedback=1 and ok_pulse=1 at edge 27, ok_pulse=0 at edge 28.
- Glitchy qualify: `sense` low for 1 cycle 5 cycles into QUALIFY -> stab restarts; ok_feedback rises 8 cycles after `sense_s` returns high; fail stays 0.
- Timeout: TIMEOUT_CYCLES=64, `sense`=0 throughout -> state=4 and fail=1 exactly 64 cycles after SETTLE entry; remains set until `enable`=0, then state=0 three edges later.
- Loss of regulation: in OK, `sense` low for 2 cycles -> ok_feedback falls 3 edges after `sense` falls, state=2; `sense` high again -> ok_feedback returns after 8 qualifying cycles with a new ok_pulse.
- Abort and simultaneous events:
  - `enable` dropped at SETTLE count 10 -> IDLE with all counters 0.
  - Separately, force stab==STABLE_CYCLES-1 on the same cycle tcnt==TIMEOUT_CYCLES-1 -> OK, not FAIL.
- Async reset: assert `rst` mid-QUALIFY and mid-OK -> all outputs 0 without a clock edge; after release, the nominal sequence repeats with identical timing.
